// File: rtl/mbtrain_sb_tx_queue.sv
// Sideband TX message queue: buffers non-zero MBTRAIN message codes and drains
// them first-word-fall-through to the sideband encoder over valid/ready.
module mbtrain_sb_tx_queue #(
    parameter int DEPTH = 4,
    parameter int MSG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic [MSG_W-1:0]         i_sideband_message,
    input  logic                     i_valid,
    input  logic                     i_sb_ready,
    output logic [MSG_W-1:0]         o_sb_message,
    output logic                     o_sb_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [MSG_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic full, empty;
    logic push_req, pop, push_ok;

    // Wrap bit distinguishes full from empty when the index bits coincide.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

    always_comb begin
        push_req   = i_en & i_valid & (i_sideband_message != '0);
        pop        = i_en & o_sb_valid & i_sb_ready;
        push_ok    = push_req & (!full | pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + PW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - PW'(1);
        end
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (!i_en) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: nothing is visible unless a pointer covers it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= i_sideband_message;
        end
    end

    assign o_sb_valid   = !empty & i_en;
    assign o_sb_message = o_sb_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
    assign o_full       = full;
    assign o_empty      = empty;
    assign o_overflow   = overflow_q;
    assign o_count      = count_q;

endmodule
